// File: rtl/alu_op_sequencer.sv
// Initiator-side sequencer for the registered 8-bit ALU: accepts requests, waits out
// the ALU latency, captures the result and returns it with a zero flag.
//
// state | meaning
// IDLE  | ready for a request; ALU drive registers hold last issued operation
// EXEC  | ALU registers its result this cycle
// CAPT  | capture ALU_RESULT into response and chain registers
// RESP  | response presented, held until RESP_READY
module alu_op_sequencer #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   REQ_VALID,
  output logic                   REQ_READY,
  input  logic [3:0]             REQ_OP,
  input  logic [7:0]             REQ_A,
  input  logic [7:0]             REQ_B,
  input  logic                   REQ_CHAIN,
  output logic [7:0]             ALU_IN_A,
  output logic [7:0]             ALU_IN_B,
  output logic [3:0]             ALU_OP_CODE,
  input  logic [7:0]             ALU_RESULT,
  output logic                   RESP_VALID,
  input  logic                   RESP_READY,
  output logic [7:0]             RESP_DATA,
  output logic                   RESP_ZERO,
  output logic [COUNT_WIDTH-1:0] OP_COUNT
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t     state;
  logic [7:0] last;

  // Held low while RESET is asserted so no request is taken in the reset cycle.
  assign REQ_READY = (state == IDLE) && !RESET;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      last        <= 8'h00;
      ALU_IN_A    <= 8'h00;
      ALU_IN_B    <= 8'h00;
      ALU_OP_CODE <= 4'h0;
      RESP_VALID  <= 1'b0;
      RESP_DATA   <= 8'h00;
      RESP_ZERO   <= 1'b0;
      OP_COUNT    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            ALU_OP_CODE <= REQ_OP;
            ALU_IN_B    <= REQ_B;
            ALU_IN_A    <= REQ_CHAIN ? last : REQ_A;
            state       <= EXEC;
          end
        end
        EXEC: begin
          state <= CAPT;
        end
        CAPT: begin
          RESP_DATA  <= ALU_RESULT;
          RESP_ZERO  <= (ALU_RESULT == 8'h00);
          last       <= ALU_RESULT;
          RESP_VALID <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (RESP_READY) begin
            RESP_VALID <= 1'b0;
            OP_COUNT   <= OP_COUNT + COUNT_WIDTH'(1);
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural registered ALU plus a
// transaction-level reference model (last result, completed-op count).
module tb_alu_op_sequencer;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic [3:0]    REQ_OP = 4'h0;
  logic [7:0]    REQ_A = 8'h00;
  logic [7:0]    REQ_B = 8'h00;
  logic          REQ_CHAIN = 1'b0;
  logic [7:0]    ALU_IN_A;
  logic [7:0]    ALU_IN_B;
  logic [3:0]    ALU_OP_CODE;
  logic [7:0]    ALU_RESULT;
  logic          RESP_VALID;
  logic          RESP_READY = 1'b0;
  logic [7:0]    RESP_DATA;
  logic          RESP_ZERO;
  logic [CW-1:0] OP_COUNT;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0] m_last  = 8'h00;
  int         m_count = 0;

  alu_op_sequencer #(.COUNT_WIDTH(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_CHAIN(REQ_CHAIN),
    .ALU_IN_A(ALU_IN_A), .ALU_IN_B(ALU_IN_B), .ALU_OP_CODE(ALU_OP_CODE),
    .ALU_RESULT(ALU_RESULT),
    .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY),
    .RESP_DATA(RESP_DATA), .RESP_ZERO(RESP_ZERO), .OP_COUNT(OP_COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return p[7:0];
      4'h3: return {a[6:0], 1'b0};
      4'h4: return {1'b0, a[7:1]};
      4'h5: return a & b;
      4'h6: return a | b;
      4'h7: return a ^ b;
      4'h8: return ~a;
      4'h9: return (a == b) ? 8'h01 : 8'h00;
      4'hA: return (a > b) ? 8'h01 : 8'h00;
      4'hB: return (a < b) ? 8'h01 : 8'h00;
      default: return {a[3:0], b[3:0]} ^ {4'h0, op};
    endcase
  endfunction

  // registered ALU sharing clock and reset
  always @(posedge CLK) begin
    if (RESET) ALU_RESULT <= 8'h00;
    else       ALU_RESULT <= alu_f(ALU_OP_CODE, ALU_IN_A, ALU_IN_B);
  end

  // Drives one transaction from IDLE; called #1 after a rising edge.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic chain, input int stall,
                        output logic [7:0] o_a, output logic [7:0] o_b, output logic [3:0] o_op,
                        output int lat, output logic [7:0] data, output logic zero,
                        output logic [CW-1:0] cnt, output bit tmo);
    int n;
    tmo = 0;
    n = 0;
    while (!REQ_READY && n < 20) begin @(posedge CLK); #1; n++; end
    if (!REQ_READY) tmo = 1;
    REQ_VALID = 1'b1; REQ_OP = op; REQ_A = a; REQ_B = b; REQ_CHAIN = chain;
    RESP_READY = 1'b0;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    o_a = ALU_IN_A; o_b = ALU_IN_B; o_op = ALU_OP_CODE;
    lat = 0;
    while (!RESP_VALID && lat < 20) begin @(posedge CLK); #1; lat++; end
    if (!RESP_VALID) tmo = 1;
    data = RESP_DATA; zero = RESP_ZERO;
    repeat (stall) begin @(posedge CLK); #1; end
    RESP_READY = 1'b1;
    @(posedge CLK); #1;
    RESP_READY = 1'b0;
    cnt = OP_COUNT;
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    REQ_VALID = 1'b0; RESP_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic release_reset();
    RESET = 1'b0;
    m_last = 8'h00; m_count = 0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (REQ_READY !== 1'b0 || RESP_VALID !== 1'b0 || RESP_DATA !== 8'h00 || RESP_ZERO !== 1'b0 ||
        ALU_IN_A !== 8'h00 || ALU_IN_B !== 8'h00 || ALU_OP_CODE !== 4'h0 || OP_COUNT !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b vld=%b data=%h z=%b a=%h b=%h op=%h cnt=%0d, want 0/0/00/0/00/00/0/0",
               REQ_READY, RESP_VALID, RESP_DATA, RESP_ZERO, ALU_IN_A, ALU_IN_B, ALU_OP_CODE, OP_COUNT);
    end
    release_reset();
    n_tests++;
    if (REQ_READY !== 1'b1 || RESP_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got rdy=%b vld=%b, want 1/0", REQ_READY, RESP_VALID);
    end
  endtask

  // Runs one op and checks it against the model; returns nothing, updates model.
  task automatic op_checked(input string name, input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic chain, input int stall);
    logic [7:0] o_a, o_b, data, exp_a, exp_r;
    logic [3:0] o_op;
    logic zero;
    logic [CW-1:0] cnt;
    int lat;
    bit tmo;
    exp_a = chain ? m_last : a;
    exp_r = alu_f(op, exp_a, b);
    run_op(op, a, b, chain, stall, o_a, o_b, o_op, lat, data, zero, cnt, tmo);
    m_last = exp_r;
    m_count++;
    n_tests++;
    if (tmo || o_a !== exp_a || o_b !== b || o_op !== op) begin
      n_fail++;
      $display("FAIL %s_issue: got tmo=%0d a=%h b=%h op=%h, want tmo=0 a=%h b=%h op=%h",
               name, tmo, o_a, o_b, o_op, exp_a, b, op);
    end
    n_tests++;
    if (lat != 2 || data !== exp_r || zero !== (exp_r == 8'h00)) begin
      n_fail++;
      $display("FAIL %s_resp: got lat=%0d data=%h zero=%b, want lat=2 data=%h zero=%b",
               name, lat, data, zero, exp_r, (exp_r == 8'h00));
    end
    n_tests++;
    if (cnt !== CW'(m_count) || RESP_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_count: got cnt=%0d vld=%b, want cnt=%0d vld=0", name, cnt, RESP_VALID, CW'(m_count));
    end
  endtask

  task automatic test_single_op();
    op_checked("add", 4'h0, 8'h05, 8'h03, 1'b0, 0);
  endtask

  task automatic test_wrap_zero();
    op_checked("sub_wrap", 4'h1, 8'h03, 8'h05, 1'b0, 0);
    op_checked("mul_zero", 4'h2, 8'h10, 8'h10, 1'b0, 1);
  endtask

  task automatic test_chaining();
    op_checked("chain_seed", 4'h0, 8'h05, 8'h03, 1'b0, 0);
    op_checked("chain_shl", 4'h3, 8'hFF, 8'h00, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    int n;
    logic [7:0] exp_r;
    exp_r = alu_f(4'h9, 8'h2A, 8'h2A);
    REQ_VALID = 1'b1; REQ_OP = 4'h9; REQ_A = 8'h2A; REQ_B = 8'h2A; REQ_CHAIN = 1'b0;
    RESP_READY = 1'b0;
    @(posedge CLK); #1;
    REQ_OP = 4'h0; REQ_A = 8'h01; REQ_B = 8'h02;   // second request held valid during stall
    n = 0;
    while (!RESP_VALID && n < 20) begin @(posedge CLK); #1; n++; end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (RESP_VALID !== 1'b1 || RESP_DATA !== exp_r || REQ_READY !== 1'b0 || ALU_IN_A !== 8'h2A) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got vld=%b data=%h rdy=%b in_a=%h, want 1/%h/0/2a",
                 i, RESP_VALID, RESP_DATA, REQ_READY, ALU_IN_A, exp_r);
      end
      @(posedge CLK); #1;
    end
    RESP_READY = 1'b1;
    @(posedge CLK); #1;
    RESP_READY = 1'b0;
    m_last = exp_r; m_count++;
    n_tests++;
    if (OP_COUNT !== CW'(m_count) || REQ_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_handshake: got cnt=%0d rdy=%b, want cnt=%0d rdy=1", OP_COUNT, REQ_READY, CW'(m_count));
    end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    n_tests++;
    if (ALU_IN_A !== 8'h01 || ALU_IN_B !== 8'h02 || ALU_OP_CODE !== 4'h0 || REQ_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second_accept: got a=%h b=%h op=%h rdy=%b, want 01/02/0/0",
               ALU_IN_A, ALU_IN_B, ALU_OP_CODE, REQ_READY);
    end
    n = 0;
    while (!RESP_VALID && n < 20) begin @(posedge CLK); #1; n++; end
    n_tests++;
    if (RESP_DATA !== 8'h03 || RESP_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second_resp: got vld=%b data=%h, want 1/03", RESP_VALID, RESP_DATA);
    end
    RESP_READY = 1'b1;
    @(posedge CLK); #1;
    RESP_READY = 1'b0;
    m_last = 8'h03; m_count++;
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    REQ_VALID = 1'b1; REQ_OP = 4'h0; REQ_A = 8'h40; REQ_B = 8'h40; REQ_CHAIN = 1'b0;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    RESP_READY = 1'b1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    n_tests++;
    if (REQ_READY !== 1'b0 || RESP_VALID !== 1'b0 || RESP_DATA !== 8'h00 || RESP_ZERO !== 1'b0 ||
        ALU_IN_A !== 8'h00 || ALU_IN_B !== 8'h00 || ALU_OP_CODE !== 4'h0 || OP_COUNT !== '0) begin
      n_fail++;
      $display("FAIL midreset_values: got rdy=%b vld=%b data=%h z=%b a=%h b=%h op=%h cnt=%0d, want all 0",
               REQ_READY, RESP_VALID, RESP_DATA, RESP_ZERO, ALU_IN_A, ALU_IN_B, ALU_OP_CODE, OP_COUNT);
    end
    RESET = 1'b0;
    m_last = 8'h00; m_count = 0;
    seen = 0;
    repeat (4) begin
      @(posedge CLK); #1;
      if (RESP_VALID !== 1'b0 || REQ_READY !== 1'b1) seen = 1;
    end
    RESP_READY = 1'b0;
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL midreset_no_resp: got stray resp/ready activity=1, want 0");
    end
    // chaining right after reset must use LAST=0
    op_checked("after_reset", 4'h0, 8'h77, 8'h11, 1'b1, 0);
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    release_reset();
    for (int i = 0; i < 17; i++)
      op_checked("wrap", 4'h0, 8'(i), 8'h01, 1'b0, 0);
    n_tests++;
    if (OP_COUNT !== CW'(1)) begin
      n_fail++;
      $display("FAIL counter_wrap: got %0d, want 1", OP_COUNT);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      op_checked("rand", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_wrap_zero();
    test_chaining();
    test_backpressure();
    test_reset_mid_op();
    test_counter_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
